// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants (nibble width, dark word, code table) and nibble decode helper
package seg7_pkg;
  localparam int NIB_W = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  // seg[6:0] codes for hex 0..F, active-low, board segment order
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0001000, 7'b1101101, 7'b0100010, 7'b0100100,
    7'b1000101, 7'b0010100, 7'b0010000, 7'b0101101,
    7'b0000000, 7'b0000100, 7'b0000001, 7'b1010000,
    7'b0011010, 7'b1100000, 7'b0010010, 7'b0010011
  };
  function automatic logic [6:0] seg_code(input logic [NIB_W-1:0] nib);
    return SEG_TBL[nib];
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: datapath-side inputs (value/dots/digit_en/lz_blank/load) and pin-side outputs (seg/an/frame_done)
interface seg7_scan_driver_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dots;
  logic [DIGITS-1:0] digit_en;
  logic lz_blank;
  logic load;
  logic [7:0] seg;
  logic [DIGITS-1:0] an;
  logic frame_done;
  modport master (output value, dots, digit_en, lz_blank, load, input seg, an, frame_done);
  modport slave (input value, dots, digit_en, lz_blank, load, output seg, an, frame_done);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble + dot + blank -> 8-bit segment word (seg[7] = dot), polarity set by SEG_ACT_LOW
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [NIB_W-1:0] nib,
  input  logic             dot,
  input  logic             blank,
  output logic [7:0]       seg
);
  always_comb seg = {~dot, blank ? 7'h7F : seg_code(nib)} ^ {8{~SEG_ACT_LOW}};
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed DIGITS-digit 7-segment driver with frame-synchronous update
// Ports: clk, rst_n (async active-low); bus.slave carries value/dots/digit_en/lz_blank/load in,
// seg (seg[7] = dot), an (one-hot when lit) and frame_done (pulse as the last slot ends) out.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV = 50000,
  parameter int BLANK = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [7:0] SEG_DARK = SEG_ACT_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] AN_DARK = AN_ACT_LOW ? '1 : '0;
  typedef logic [DIGITS-1:0][NIB_W-1:0] nibs_t;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  nibs_t stg_val_q, stg_val_d, shd_val_q, shd_val_d;
  logic [DIGITS-1:0] stg_dot_q, stg_dot_d, stg_en_q, stg_en_d;
  logic [DIGITS-1:0] shd_dot_q, shd_dot_d, shd_en_q, shd_en_d;
  logic pend_q, pend_d;
  logic [7:0] seg_q, seg_d, seg_raw;
  logic [DIGITS-1:0] an_q, an_d, oh, sup;
  logic fd_q, fd_d;
  logic tick, wrap, commit, run;
  always_comb begin
    tick = presc_q == PW'(DIV - 1);
    wrap = tick && idx_q == IW'(DIGITS - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    stg_val_d = bus.load ? bus.value : stg_val_q;
    stg_dot_d = bus.load ? bus.dots : stg_dot_q;
    stg_en_d = bus.load ? bus.digit_en : stg_en_q;
    // a load coinciding with the wrap commits straight through the staging mux
    commit = wrap && (pend_q || bus.load);
    pend_d = !wrap && (pend_q || bus.load);
    shd_val_d = commit ? stg_val_d : shd_val_q;
    shd_dot_d = commit ? stg_dot_d : shd_dot_q;
    shd_en_d = commit ? stg_en_d : shd_en_q;
    // walk from the top digit down; suppression stops at the first nonzero nibble
    run = 1'b1;
    sup = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run && shd_val_q[i] == '0;
      sup[i] = run && bus.lz_blank && i != 0;
    end
    oh = DIGITS'(1) << idx_q;
    an_d = presc_q < PW'(BLANK) ? AN_DARK : AN_ACT_LOW ? ~oh : oh;
    seg_d = seg_raw;
    fd_d = wrap;
  end
  seg7_decode #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_dec (
    .nib(shd_val_q[idx_q]),
    .dot(shd_dot_q[idx_q] & shd_en_q[idx_q]),
    .blank(sup[idx_q] | ~shd_en_q[idx_q]),
    .seg(seg_raw)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q <= '0;
      stg_val_q <= '0;
      stg_dot_q <= '0;
      stg_en_q <= '0;
      shd_val_q <= '0;
      shd_dot_q <= '0;
      shd_en_q <= '0;
      pend_q <= 1'b0;
      seg_q <= SEG_DARK;
      an_q <= AN_DARK;
      fd_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q <= idx_d;
      stg_val_q <= stg_val_d;
      stg_dot_q <= stg_dot_d;
      stg_en_q <= stg_en_d;
      shd_val_q <= shd_val_d;
      shd_dot_q <= shd_dot_d;
      shd_en_q <= shd_en_d;
      pend_q <= pend_d;
      seg_q <= seg_d;
      an_q <= an_d;
      fd_q <= fd_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.frame_done = fd_q;
endmodule
